// File: rtl/ex_pkg.sv
// Shared opcode constants, ALU operation encoding and EX handshake states.
// Imported by the ALU and the EX stage.
package ex_pkg;

    localparam logic [6:0] LUI         = 7'b0110111;
    localparam logic [6:0] IMM_REG_ALU = 7'b0010011;
    localparam logic [6:0] REG_REG_ALU = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic {
        ST_GET,
        ST_GIVE
    } ex_state_e;

    // SUB exists only for register-register ops; bit30 on an immediate ADD is immediate data.
    function automatic alu_op_e decode_op(input logic [2:0] funct3,
                                          input logic       bit30,
                                          input logic       is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU; shifts use only the low log2(BITSIZE) bits of B.
module alu
    import ex_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic [BITSIZE-1:0] A,
    input  logic [BITSIZE-1:0] B,
    input  alu_op_e            op,
    output logic [BITSIZE-1:0] result
);

    localparam int SHW = $clog2(BITSIZE);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    assign shamt = B[SHW-1:0];
    assign lt_s  = $signed(A) < $signed(B);
    assign lt_u  = A < B;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = A + B;
            ALU_SUB:  result = A - B;
            ALU_SLL:  result = A << shamt;
            ALU_SLT:  result = {{(BITSIZE-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(BITSIZE-1){1'b0}}, lt_u};
            ALU_XOR:  result = A ^ B;
            ALU_SRL:  result = A >> shamt;
            ALU_SRA:  result = $unsigned($signed(A) >>> shamt);
            ALU_OR:   result = A | B;
            ALU_AND:  result = A & B;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex.sv
// Execute stage: two-state get/give handshake around a registered ALU result.
// One instruction is accepted in GET and held stable in GIVE until downstream takes it.
module ex
    import ex_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               ID_EX_give_i,
    output logic               EX_ID_get_o,
    input  logic [31:0]        ID_EX_instruction_i,
    input  logic [BITSIZE-1:0] ID_EX_rs1_i,
    input  logic [BITSIZE-1:0] ID_EX_rs2_i,
    output logic               EX_MEM_give_o,
    input  logic               MEM_EX_get_i,
    output logic [31:0]        EX_MEM_instruction_o,
    output logic [BITSIZE-1:0] EX_MEM_result_o,
    output logic [4:0]         EX_MEM_rd_o,
    output logic               EX_MEM_we_o
);

    ex_state_e          state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [BITSIZE-1:0] result_q, result_d;
    logic [4:0]         rd_q, rd_d;
    logic               we_q, we_d;

    logic [6:0]         opcode;
    logic [31:0]        lui_word;
    logic [BITSIZE-1:0] b_operand;
    logic [BITSIZE-1:0] alu_result;
    alu_op_e            alu_op;

    always_comb begin
        opcode    = ID_EX_instruction_i[6:0];
        lui_word  = {ID_EX_instruction_i[31:12], 12'b0};
        alu_op    = decode_op(ID_EX_instruction_i[14:12], ID_EX_instruction_i[30],
                              opcode == REG_REG_ALU);
        b_operand = ID_EX_rs2_i;
        if (opcode == IMM_REG_ALU)
            b_operand = BITSIZE'($signed(ID_EX_instruction_i[31:20]));
    end

    alu #(.BITSIZE(BITSIZE)) u_alu (
        .A      (ID_EX_rs1_i),
        .B      (b_operand),
        .op     (alu_op),
        .result (alu_result)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        result_d = result_q;
        rd_d     = rd_q;
        we_d     = we_q;
        case (state_q)
            ST_GET: begin
                if (ID_EX_give_i) begin
                    instr_d = ID_EX_instruction_i;
                    rd_d    = ID_EX_instruction_i[11:7];
                    state_d = ST_GIVE;
                    case (opcode)
                        LUI: begin
                            result_d = BITSIZE'(lui_word);
                            we_d     = 1'b1;
                        end
                        IMM_REG_ALU, REG_REG_ALU: begin
                            result_d = alu_result;
                            we_d     = 1'b1;
                        end
                        // Unknown opcodes still flow downstream, just without a write.
                        default: begin
                            result_d = '0;
                            we_d     = 1'b0;
                        end
                    endcase
                end
            end
            ST_GIVE: begin
                if (MEM_EX_get_i)
                    state_d = ST_GET;
            end
            default: state_d = ST_GET;
        endcase
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_GET;
            instr_q  <= '0;
            result_q <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
        end
    end

    assign EX_ID_get_o          = (state_q == ST_GET);
    assign EX_MEM_give_o        = (state_q == ST_GIVE);
    assign EX_MEM_instruction_o = instr_q;
    assign EX_MEM_result_o      = result_q;
    assign EX_MEM_rd_o          = rd_q;
    assign EX_MEM_we_o          = we_q;

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the EX stage handshake and ALU.
module tb_ex;

    logic        clk = 1'b0;
    logic        resetn_i;
    logic        ID_EX_give_i;
    logic        EX_ID_get_o;
    logic [31:0] ID_EX_instruction_i;
    logic [31:0] ID_EX_rs1_i;
    logic [31:0] ID_EX_rs2_i;
    logic        EX_MEM_give_o;
    logic        MEM_EX_get_i;
    logic [31:0] EX_MEM_instruction_o;
    logic [31:0] EX_MEM_result_o;
    logic [4:0]  EX_MEM_rd_o;
    logic        EX_MEM_we_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex #(.BITSIZE(32)) dut (
        .clk                  (clk),
        .resetn_i             (resetn_i),
        .ID_EX_give_i         (ID_EX_give_i),
        .EX_ID_get_o          (EX_ID_get_o),
        .ID_EX_instruction_i  (ID_EX_instruction_i),
        .ID_EX_rs1_i          (ID_EX_rs1_i),
        .ID_EX_rs2_i          (ID_EX_rs2_i),
        .EX_MEM_give_o        (EX_MEM_give_o),
        .MEM_EX_get_i         (MEM_EX_get_i),
        .EX_MEM_instruction_o (EX_MEM_instruction_o),
        .EX_MEM_result_o      (EX_MEM_result_o),
        .EX_MEM_rd_o          (EX_MEM_rd_o),
        .EX_MEM_we_o          (EX_MEM_we_o)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Called at posedge+1 in GET; returns at posedge+1 with the instruction in GIVE.
    task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        ID_EX_instruction_i = instr;
        ID_EX_rs1_i         = rs1;
        ID_EX_rs2_i         = rs2;
        ID_EX_give_i        = 1'b1;
        @(posedge clk); #1;
        ID_EX_give_i        = 1'b0;
    endtask

    task automatic drain();
        MEM_EX_get_i = 1'b1;
        @(posedge clk); #1;
        MEM_EX_get_i = 1'b0;
    endtask

    task automatic test_reset();
        resetn_i            = 1'b0;
        ID_EX_give_i        = 1'b1;
        MEM_EX_get_i        = 1'b0;
        ID_EX_instruction_i = 32'h1234_5037;
        ID_EX_rs1_i         = 32'hFFFF_FFFF;
        ID_EX_rs2_i         = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        total++; if (EX_ID_get_o !== 1'b1) begin bad++; $display("FAIL reset_get got=%b want=1", EX_ID_get_o); end
        total++; if (EX_MEM_give_o !== 1'b0) begin bad++; $display("FAIL reset_give got=%b want=0", EX_MEM_give_o); end
        total++; if (EX_MEM_result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", EX_MEM_result_o); end
        total++; if (EX_MEM_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", EX_MEM_we_o); end
        total++; if (EX_MEM_rd_o !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", EX_MEM_rd_o); end
        ID_EX_give_i = 1'b0;
        resetn_i     = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins [17];
        logic [31:0] a   [17];
        logic [31:0] b   [17];
        logic [31:0] exp [17];
        logic [4:0]  erd [17];
        ins[0]  = enc_i(12'hFFF, 5'd2, 3'b000, 5'd1);            a[0]  = 32'd5;          b[0]  = 32'h5555_5555; exp[0]  = 32'd4;          erd[0]  = 5'd1;
        ins[1]  = enc_r(7'b0100000, 5'd5, 5'd4, 3'b000, 5'd3);   a[1]  = 32'd3;          b[1]  = 32'd5;         exp[1]  = 32'hFFFF_FFFE; erd[1]  = 5'd3;
        ins[2]  = enc_r(7'b0000000, 5'd5, 5'd4, 3'b011, 5'd6);   a[2]  = 32'd3;          b[2]  = 32'd5;         exp[2]  = 32'd1;         erd[2]  = 5'd6;
        ins[3]  = enc_r(7'b0000000, 5'd5, 5'd4, 3'b010, 5'd7);   a[3]  = 32'd3;          b[3]  = 32'd5;         exp[3]  = 32'd1;         erd[3]  = 5'd7;
        ins[4]  = enc_r(7'b0000000, 5'd5, 5'd4, 3'b010, 5'd8);   a[4]  = 32'hFFFF_FFFF;  b[4]  = 32'd1;         exp[4]  = 32'd1;         erd[4]  = 5'd8;
        ins[5]  = enc_r(7'b0000000, 5'd5, 5'd4, 3'b011, 5'd9);   a[5]  = 32'hFFFF_FFFF;  b[5]  = 32'd1;         exp[5]  = 32'd0;         erd[5]  = 5'd9;
        ins[6]  = enc_i(12'h404, 5'd2, 3'b101, 5'd10);           a[6]  = 32'h8000_0000;  b[6]  = 32'd0;         exp[6]  = 32'hF800_0000; erd[6]  = 5'd10;
        ins[7]  = enc_i(12'h004, 5'd2, 3'b101, 5'd11);           a[7]  = 32'h8000_0000;  b[7]  = 32'd0;         exp[7]  = 32'h0800_0000; erd[7]  = 5'd11;
        ins[8]  = enc_r(7'b0000000, 5'd5, 5'd4, 3'b001, 5'd12);  a[8]  = 32'd1;          b[8]  = 32'd33;        exp[8]  = 32'd2;         erd[8]  = 5'd12;
        ins[9]  = enc_r(7'b0000000, 5'd5, 5'd4, 3'b100, 5'd13);  a[9]  = 32'hF0F0_00FF;  b[9]  = 32'h0FF0_0F0F; exp[9]  = 32'hFF00_0FF0; erd[9]  = 5'd13;
        ins[10] = enc_r(7'b0000000, 5'd5, 5'd4, 3'b110, 5'd14);  a[10] = 32'hF0F0_00FF;  b[10] = 32'h0FF0_0F0F; exp[10] = 32'hFFF0_0FFF; erd[10] = 5'd14;
        ins[11] = enc_r(7'b0000000, 5'd5, 5'd4, 3'b111, 5'd15);  a[11] = 32'hF0F0_00FF;  b[11] = 32'h0FF0_0F0F; exp[11] = 32'h00F0_000F; erd[11] = 5'd15;
        ins[12] = enc_r(7'b0000000, 5'd5, 5'd4, 3'b000, 5'd16);  a[12] = 32'hFFFF_FFFF;  b[12] = 32'd2;         exp[12] = 32'd1;         erd[12] = 5'd16;
        ins[13] = enc_i(12'h400, 5'd2, 3'b000, 5'd17);           a[13] = 32'd1;          b[13] = 32'hDEAD_BEEF; exp[13] = 32'h0000_0401; erd[13] = 5'd17;
        ins[14] = enc_i(12'h0F0, 5'd2, 3'b111, 5'd18);           a[14] = 32'hFFFF_FFFF;  b[14] = 32'd0;         exp[14] = 32'h0000_00F0; erd[14] = 5'd18;
        ins[15] = enc_r(7'b0000000, 5'd5, 5'd4, 3'b000, 5'd0);   a[15] = 32'd7;          b[15] = 32'd8;         exp[15] = 32'd15;        erd[15] = 5'd0;
        ins[16] = enc_r(7'b0100000, 5'd5, 5'd4, 3'b101, 5'd19);  a[16] = 32'h8000_0000;  b[16] = 32'h0000_0024; exp[16] = 32'hF800_0000; erd[16] = 5'd19;
        for (int i = 0; i < 17; i++) begin
            send(ins[i], a[i], b[i]);
            total++; if (EX_MEM_give_o !== 1'b1) begin bad++; $display("FAIL alu%0d_give got=%b want=1", i, EX_MEM_give_o); end
            total++; if (EX_ID_get_o !== 1'b0) begin bad++; $display("FAIL alu%0d_get got=%b want=0", i, EX_ID_get_o); end
            total++; if (EX_MEM_result_o !== exp[i]) begin bad++; $display("FAIL alu%0d_result got=%h want=%h", i, EX_MEM_result_o, exp[i]); end
            total++; if (EX_MEM_rd_o !== erd[i]) begin bad++; $display("FAIL alu%0d_rd got=%0d want=%0d", i, EX_MEM_rd_o, erd[i]); end
            total++; if (EX_MEM_we_o !== 1'b1) begin bad++; $display("FAIL alu%0d_we got=%b want=1", i, EX_MEM_we_o); end
            total++; if (EX_MEM_instruction_o !== ins[i]) begin bad++; $display("FAIL alu%0d_instr got=%h want=%h", i, EX_MEM_instruction_o, ins[i]); end
            drain();
            total++; if (EX_ID_get_o !== 1'b1 || EX_MEM_give_o !== 1'b0) begin bad++; $display("FAIL alu%0d_back_to_get got=%b%b want=10", i, EX_ID_get_o, EX_MEM_give_o); end
        end
    endtask

    task automatic test_lui_stall();
        send(32'h1234_52B7, 32'hAAAA_AAAA, 32'h5555_5555);
        for (int c = 0; c < 5; c++) begin
            ID_EX_give_i        = c[0] ? 1'b0 : 1'b1;
            ID_EX_instruction_i = 32'h0010_0093 + c;
            ID_EX_rs1_i         = 32'd100 + c;
            @(posedge clk); #1;
            total++; if (EX_MEM_result_o !== 32'h1234_5000) begin bad++; $display("FAIL lui_stall%0d_result got=%h want=12345000", c, EX_MEM_result_o); end
            total++; if (EX_MEM_give_o !== 1'b1 || EX_ID_get_o !== 1'b0) begin bad++; $display("FAIL lui_stall%0d_hs got give=%b get=%b want give=1 get=0", c, EX_MEM_give_o, EX_ID_get_o); end
            total++; if (EX_MEM_rd_o !== 5'd5 || EX_MEM_we_o !== 1'b1) begin bad++; $display("FAIL lui_stall%0d_rdwe got rd=%0d we=%b want rd=5 we=1", c, EX_MEM_rd_o, EX_MEM_we_o); end
            total++; if (EX_MEM_instruction_o !== 32'h1234_52B7) begin bad++; $display("FAIL lui_stall%0d_instr got=%h want=123452b7", c, EX_MEM_instruction_o); end
        end
        ID_EX_give_i = 1'b0;
        drain();
        total++; if (EX_ID_get_o !== 1'b1 || EX_MEM_give_o !== 1'b0) begin bad++; $display("FAIL lui_release got get=%b give=%b want get=1 give=0", EX_ID_get_o, EX_MEM_give_o); end
        @(posedge clk); #1;
        total++; if (EX_MEM_result_o !== 32'h1234_5000) begin bad++; $display("FAIL get_idle_hold got=%h want=12345000", EX_MEM_result_o); end
    endtask

    task automatic test_illegal();
        send(32'hABCD_E0FF, 32'h1111_1111, 32'h2222_2222);
        total++; if (EX_MEM_give_o !== 1'b1) begin bad++; $display("FAIL illegal_give got=%b want=1", EX_MEM_give_o); end
        total++; if (EX_MEM_we_o !== 1'b0) begin bad++; $display("FAIL illegal_we got=%b want=0", EX_MEM_we_o); end
        total++; if (EX_MEM_result_o !== 32'h0) begin bad++; $display("FAIL illegal_result got=%h want=0", EX_MEM_result_o); end
        total++; if (EX_MEM_instruction_o !== 32'hABCD_E0FF) begin bad++; $display("FAIL illegal_instr got=%h want=abcde0ff", EX_MEM_instruction_o); end
        drain();
        total++; if (EX_ID_get_o !== 1'b1) begin bad++; $display("FAIL illegal_done got=%b want=1", EX_ID_get_o); end
    endtask

    task automatic test_reset_in_give();
        send(enc_i(12'h007, 5'd2, 3'b000, 5'd4), 32'd10, 32'd0);
        total++; if (EX_MEM_give_o !== 1'b1) begin bad++; $display("FAIL rig_pre_give got=%b want=1", EX_MEM_give_o); end
        #2 resetn_i = 1'b0;
        #1;
        total++; if (EX_MEM_give_o !== 1'b0 || EX_ID_get_o !== 1'b1) begin bad++; $display("FAIL rig_async got give=%b get=%b want give=0 get=1", EX_MEM_give_o, EX_ID_get_o); end
        total++; if (EX_MEM_result_o !== 32'h0 || EX_MEM_we_o !== 1'b0 || EX_MEM_rd_o !== 5'd0) begin bad++; $display("FAIL rig_clear got res=%h we=%b rd=%0d want 0 0 0", EX_MEM_result_o, EX_MEM_we_o, EX_MEM_rd_o); end
        total++; if (EX_MEM_instruction_o !== 32'h0) begin bad++; $display("FAIL rig_instr got=%h want=0", EX_MEM_instruction_o); end
        @(posedge clk); #1;
        resetn_i = 1'b1;
        send(enc_i(12'h003, 5'd2, 3'b000, 5'd9), 32'd20, 32'd0);
        total++; if (EX_MEM_give_o !== 1'b1 || EX_MEM_result_o !== 32'd23) begin bad++; $display("FAIL rig_first_accept got give=%b res=%h want give=1 res=17", EX_MEM_give_o, EX_MEM_result_o); end
        total++; if (EX_MEM_rd_o !== 5'd9) begin bad++; $display("FAIL rig_first_rd got=%0d want=9", EX_MEM_rd_o); end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_lui_stall();
        test_illegal();
        test_reset_in_give();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
